// File: rtl/ovf_monitor.sv
// ============================================================================
// Module   : ovf_monitor
// Purpose  : Watches an accumulator overflow bit, counts its rising edges,
//            raises an alarm at OVF_LIMIT and posts one-deep event words.
// Options  : define OVF_MONITOR_PEAK_HOLD_EN to build the i_data peak tracker.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ovf_monitor #(
  parameter logic [3:0] OVF_LIMIT = 4'd3,
  parameter logic [5:0] PEAK_INIT = 6'd0
) (
  input  logic       clock,
  input  logic       i_rst,
  input  logic [5:0] i_data,
  input  logic       i_overflow,
  input  logic       i_clear,
  input  logic       i_evt_ready,
  output logic [6:0] o_evt_data,
  output logic       o_evt_valid,
  output logic [3:0] o_ovf_count,
  output logic       o_alarm,
  output logic       o_lost,
  output logic [5:0] o_peak
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COUNTING = 2'd1,
    S_ALARM    = 2'd2
  } state_t;

  localparam logic [3:0] C_COUNT_MAX = 4'd15;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_ovf_q;
  logic       w_edge;
  logic [3:0] r_count;
  logic [3:0] w_count_inc;
  logic [3:0] w_count_nxt;
  logic       r_alarm;

  logic       r_evt_valid;
  logic [6:0] r_evt_data;
  logic       r_lost;
  logic       w_evt_load;
  logic       w_evt_drain;
  logic       w_evt_drop;

  // --------------------------------------------------------------------------
  // Edge detect, saturating count and state decode
  // --------------------------------------------------------------------------
  always_comb begin
    w_edge      = i_overflow & ~r_ovf_q;
    w_count_inc = (r_count == C_COUNT_MAX) ? r_count : r_count + 4'd1;
    w_count_nxt = r_count;
    w_state_nxt = r_state;

    // Clear wins over a coincident edge: the edge is not counted here.
    if (i_clear) begin
      w_count_nxt = 4'd0;
      w_state_nxt = S_IDLE;
    end else if (w_edge) begin
      w_count_nxt = w_count_inc;
      case (r_state)
        S_IDLE, S_COUNTING: w_state_nxt = (w_count_inc >= OVF_LIMIT) ? S_ALARM : S_COUNTING;
        S_ALARM:            w_state_nxt = S_ALARM;
        default:            w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ovf_q <= 1'b0;
      r_count <= 4'd0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ovf_q <= i_overflow;
      r_count <= w_count_nxt;
      r_alarm <= (w_state_nxt == S_ALARM);
    end
  end

  // --------------------------------------------------------------------------
  // One-entry event buffer; a draining slot may be refilled in the same cycle
  // --------------------------------------------------------------------------
  always_comb begin
    w_evt_drain = r_evt_valid & i_evt_ready;
    w_evt_load  = w_edge & (~r_evt_valid | i_evt_ready);
    w_evt_drop  = w_edge & r_evt_valid & ~i_evt_ready;
  end

  always_ff @(posedge clock) begin
    if (i_rst) begin
      r_evt_valid <= 1'b0;
      r_evt_data  <= 7'd0;
    end else if (w_evt_load) begin
      r_evt_valid <= 1'b1;
      r_evt_data  <= {1'b1, i_data};
    end else if (w_evt_drain) begin
      r_evt_valid <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (i_rst || i_clear) begin
      r_lost <= 1'b0;
    end else if (w_evt_drop) begin
      r_lost <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Optional peak tracker
  // --------------------------------------------------------------------------
`ifdef OVF_MONITOR_PEAK_HOLD_EN
  logic [5:0] r_peak;

  always_ff @(posedge clock) begin
    if (i_rst || i_clear) begin
      r_peak <= PEAK_INIT;
    end else if (i_data > r_peak) begin
      r_peak <= i_data;
    end
  end

  assign o_peak = r_peak;
`else
  logic w_peak_init_unused;

  assign w_peak_init_unused = ^PEAK_INIT;
  assign o_peak             = 6'd0;
`endif

  assign o_evt_data  = r_evt_data;
  assign o_evt_valid = r_evt_valid;
  assign o_ovf_count = r_count;
  assign o_alarm     = r_alarm;
  assign o_lost      = r_lost;

endmodule

`default_nettype wire

// File: tb/tb_ovf_monitor.sv
// ============================================================================
// Module   : tb_ovf_monitor
// Purpose  : Vector-table bench for ovf_monitor (default limit 3, plus limit 1).
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ovf_monitor;

  logic       clock = 1'b0;
  logic       i_rst, i_overflow, i_clear, i_evt_ready;
  logic [5:0] i_data;
  logic [6:0] o_evt_data, l1_evt_data;
  logic       o_evt_valid, o_alarm, o_lost;
  logic       l1_evt_valid, l1_alarm, l1_lost;
  logic [3:0] o_ovf_count, l1_ovf_count;
  logic [5:0] o_peak, l1_peak;

  always #5 clock = ~clock;

  ovf_monitor dut (
    .clock(clock), .i_rst(i_rst), .i_data(i_data), .i_overflow(i_overflow),
    .i_clear(i_clear), .i_evt_ready(i_evt_ready), .o_evt_data(o_evt_data),
    .o_evt_valid(o_evt_valid), .o_ovf_count(o_ovf_count), .o_alarm(o_alarm),
    .o_lost(o_lost), .o_peak(o_peak)
  );

  ovf_monitor #(.OVF_LIMIT(4'd1), .PEAK_INIT(6'd0)) dut_l1 (
    .clock(clock), .i_rst(i_rst), .i_data(i_data), .i_overflow(i_overflow),
    .i_clear(i_clear), .i_evt_ready(i_evt_ready), .o_evt_data(l1_evt_data),
    .o_evt_valid(l1_evt_valid), .o_ovf_count(l1_ovf_count), .o_alarm(l1_alarm),
    .o_lost(l1_lost), .o_peak(l1_peak)
  );

  typedef struct {
    logic       rst, clr, ovf, rdy;
    logic [5:0] data;
    logic       exp_valid;
    logic [6:0] exp_data;
    logic       chk_data;
    logic [3:0] exp_cnt;
    logic       exp_alarm, exp_lost;
    logic [5:0] exp_peak;
    logic       chk_peak;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic rst, clr, ovf, rdy, input logic [5:0] data,
                              input logic ev, input logic [6:0] ed, input logic cd,
                              input logic [3:0] cnt, input logic al, lo,
                              input logic [5:0] pe, input logic cp);
    vec_t v;
    v.rst = rst; v.clr = clr; v.ovf = ovf; v.rdy = rdy; v.data = data;
    v.exp_valid = ev; v.exp_data = ed; v.chk_data = cd; v.exp_cnt = cnt;
    v.exp_alarm = al; v.exp_lost = lo; v.exp_peak = pe; v.chk_peak = cp;
    return v;
  endfunction

  // Expected o_peak for a tracked maximum, depending on the build.
  function automatic logic [5:0] pk(input logic [5:0] v);
`ifdef OVF_MONITOR_PEAK_HOLD_EN
    return v;
`else
    return 6'd0 & v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, clr, ovf, rdy, input logic [5:0] data);
    @(negedge clock);
    i_rst = rst; i_clear = clr; i_overflow = ovf; i_evt_ready = rdy; i_data = data;
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_clear = 1'b0; i_overflow = 1'b0; i_evt_ready = 1'b1; i_data = 6'd0;

    // Basic event pulse, counting to the alarm
    vecs.push_back(mk(1,0,0,1,6'h00, 0,7'h00,1, 4'd0,0,0, 6'd0,1));
    vecs.push_back(mk(0,0,1,1,6'h05, 1,7'h45,1, 4'd1,0,0, 6'd0,0));
    vecs.push_back(mk(0,0,1,1,6'h09, 0,7'h00,0, 4'd1,0,0, 6'd0,0));
    vecs.push_back(mk(0,0,0,1,6'h00, 0,7'h00,0, 4'd1,0,0, 6'd0,0));
    vecs.push_back(mk(0,0,1,1,6'h07, 1,7'h47,1, 4'd2,0,0, 6'd0,0));
    vecs.push_back(mk(0,0,0,1,6'h00, 0,7'h00,0, 4'd2,0,0, 6'd0,0));
    vecs.push_back(mk(0,0,1,1,6'h03, 1,7'h43,1, 4'd3,1,0, 6'd0,0));
    vecs.push_back(mk(0,0,0,1,6'h00, 0,7'h00,0, 4'd3,1,0, 6'd0,0));
    // 20 more edges: count saturates at 15
    for (int i = 1; i <= 20; i++) begin
      logic [5:0] d;
      logic [3:0] c;
      d = 6'(i);
      c = (3 + i > 15) ? 4'd15 : 4'(3 + i);
      vecs.push_back(mk(0,0,1,1,d, 1,{1'b1,d},1, c,1,0, 6'd0,0));
      vecs.push_back(mk(0,0,0,1,6'h00, 0,7'h00,0, c,1,0, 6'd0,0));
    end
    // Backpressure, dropped event, back-to-back refill
    vecs.push_back(mk(0,1,0,1,6'h00, 0,7'h00,0, 4'd0,0,0, 6'd0,0));
    vecs.push_back(mk(0,0,1,0,6'h11, 1,7'h51,1, 4'd1,0,0, 6'd0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 1,7'h51,1, 4'd1,0,0, 6'd0,0));
    vecs.push_back(mk(0,0,1,0,6'h22, 1,7'h51,1, 4'd2,0,1, 6'd0,0));
    vecs.push_back(mk(0,0,0,1,6'h00, 0,7'h00,0, 4'd2,0,1, 6'd0,0));
    vecs.push_back(mk(0,0,1,0,6'h01, 1,7'h41,1, 4'd3,1,1, 6'd0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 1,7'h41,1, 4'd3,1,1, 6'd0,0));
    vecs.push_back(mk(0,0,1,1,6'h02, 1,7'h42,1, 4'd4,1,1, 6'd0,0));
    vecs.push_back(mk(0,0,0,0,6'h00, 1,7'h42,1, 4'd4,1,1, 6'd0,0));
    // Clear coincident with an edge in ALARM: not counted, still buffered
    vecs.push_back(mk(0,1,1,1,6'h0A, 1,7'h4A,1, 4'd0,0,0, 6'd0,1));
    vecs.push_back(mk(0,0,1,0,6'h00, 1,7'h4A,1, 4'd0,0,0, 6'd0,1));
    // Reset (with clear) mid-handshake, then overflow high right after reset
    vecs.push_back(mk(1,1,0,0,6'h00, 0,7'h00,1, 4'd0,0,0, 6'd0,1));
    vecs.push_back(mk(0,0,1,0,6'h3F, 1,7'h7F,1, 4'd1,0,0, pk(6'd63),1));
    vecs.push_back(mk(0,0,0,1,6'h00, 0,7'h00,0, 4'd1,0,0, pk(6'd63),1));
    // Peak tracking 10, 40, 20 then clear
    vecs.push_back(mk(1,0,0,1,6'h00, 0,7'h00,1, 4'd0,0,0, 6'd0,1));
    vecs.push_back(mk(0,0,0,1,6'd10, 0,7'h00,0, 4'd0,0,0, pk(6'd10),1));
    vecs.push_back(mk(0,0,0,1,6'd40, 0,7'h00,0, 4'd0,0,0, pk(6'd40),1));
    vecs.push_back(mk(0,0,0,1,6'd20, 0,7'h00,0, 4'd0,0,0, pk(6'd40),1));
    vecs.push_back(mk(0,1,0,1,6'd5,  0,7'h00,0, 4'd0,0,0, 6'd0,1));
    vecs.push_back(mk(0,0,0,1,6'd5,  0,7'h00,0, 4'd0,0,0, pk(6'd5),1));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].clr, vecs[i].ovf, vecs[i].rdy, vecs[i].data);
      check($sformatf("v%0d valid", i), 32'(o_evt_valid), 32'(vecs[i].exp_valid));
      if (vecs[i].chk_data)
        check($sformatf("v%0d data", i), 32'(o_evt_data), 32'(vecs[i].exp_data));
      check($sformatf("v%0d count", i), 32'(o_ovf_count), 32'(vecs[i].exp_cnt));
      check($sformatf("v%0d alarm", i), 32'(o_alarm), 32'(vecs[i].exp_alarm));
      check($sformatf("v%0d lost", i), 32'(o_lost), 32'(vecs[i].exp_lost));
      if (vecs[i].chk_peak)
        check($sformatf("v%0d peak", i), 32'(o_peak), 32'(vecs[i].exp_peak));
    end

    // OVF_LIMIT = 1: IDLE goes straight to ALARM on the first edge
    drive(1, 0, 0, 1, 6'h00);
    check("l1 reset alarm", 32'(l1_alarm), 32'd0);
    drive(0, 0, 1, 1, 6'h12);
    check("l1 first edge alarm", 32'(l1_alarm), 32'd1);
    check("l1 first edge count", 32'(l1_ovf_count), 32'd1);
    check("l1 first edge data", 32'(l1_evt_data), 32'h52);
    check("lim3 first edge alarm", 32'(o_alarm), 32'd0);
    drive(0, 0, 0, 1, 6'h00);
    check("l1 alarm held", 32'(l1_alarm), 32'd1);
    check("l1 drained valid", 32'(l1_evt_valid), 32'd0);
    drive(0, 1, 0, 1, 6'h00);
    check("l1 clear alarm", 32'(l1_alarm), 32'd0);
    check("l1 clear count", 32'(l1_ovf_count), 32'd0);
    check("l1 clear lost", 32'(l1_lost), 32'd0);
    check("l1 peak after clear", 32'(l1_peak), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ovf_monitor.md
OVF_MONITOR -- requirements
Module: ovf_monitor

Interface
REQ-001 SHALL have parameter OVF_LIMIT, default 4'd3: overflow-edge count at which ALARM is entered; legal range 1..15.
REQ-002 SHALL have parameter PEAK_INIT, default 6'd0: value loaded into the peak register on reset and on clear.
REQ-003 SHALL have port clock, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_data, input, 6: accumulator value from the upstream feedback accumulator.
REQ-006 SHALL have port i_overflow, input, 1: accumulator overflow bit (bit 6 of its sum).
REQ-007 SHALL have port i_clear, input, 1: synchronous statistics clear, active-high.
REQ-008 SHALL have port i_evt_ready, input, 1: downstream accepts the event word.
REQ-009 SHALL have port o_evt_data, output, 7: event word {overflow flag, data[5:0]}.
REQ-010 SHALL have port o_evt_valid, output, 1: event word valid.
REQ-011 SHALL have port o_ovf_count, output, 4: saturating count of overflow rising edges.
REQ-012 SHALL have port o_alarm, output, 1: high while the FSM is in ALARM.
REQ-013 SHALL have port o_lost, output, 1: sticky flag set when an event is dropped.
REQ-014 SHALL have port o_peak, output, 6: maximum i_data seen since reset or clear.

Function
REQ-015 SHALL register i_overflow into ovf_q each cycle; edge = i_overflow AND NOT ovf_q.
REQ-016 SHALL implement FSM states IDLE (count 0), COUNTING (0 < count < OVF_LIMIT) and ALARM (count >= OVF_LIMIT).
REQ-017 SHALL, on each edge without i_clear, increment o_ovf_count at that same clock edge, saturating at 15 (no wrap).
REQ-018 SHALL transition IDLE->COUNTING on the first edge, COUNTING->ALARM when the incremented count reaches OVF_LIMIT, IDLE->ALARM directly when OVF_LIMIT = 1; ALARM SHALL be left only by i_clear or i_rst.
REQ-019 SHALL drive o_alarm as a registered decode of state ALARM, rising on the same edge the count reaches OVF_LIMIT.
REQ-020 SHALL provide a one-entry event buffer: on an edge, capture {1'b1, i_data} and set o_evt_valid, visible one cycle after the sampling edge.
REQ-021 SHALL keep o_evt_data and o_evt_valid stable while o_evt_valid = 1 and i_evt_ready = 0.
REQ-022 SHALL clear o_evt_valid on a cycle with o_evt_valid = 1 and i_evt_ready = 1, unless a new edge occurs in that cycle, in which case the new word is loaded and o_evt_valid stays 1 (back-to-back, no bubble).
REQ-023 SHALL, on an edge while the buffer is full and not draining, keep the old word, still count the edge, and set o_lost.
REQ-024 SHALL, on i_clear, set count to 0, state to IDLE, o_alarm to 0, o_lost to 0 and peak to PEAK_INIT; a coincident edge SHALL NOT be counted but SHALL still be offered to the event buffer; i_clear SHALL NOT flush a pending event.
REQ-025 SHALL ignore i_evt_ready when o_evt_valid = 0.

Reset
REQ-026 SHALL, with i_rst = 1 at a clock edge, set state to IDLE, ovf_q to 0, o_ovf_count to 0, o_alarm to 0, o_evt_valid to 0, o_evt_data to 0, o_lost to 0 and peak to PEAK_INIT.
REQ-027 SHALL give i_rst priority over i_clear and all other inputs; reset mid-handshake SHALL discard the pending event.
REQ-028 SHALL treat i_overflow = 1 on the first cycle after reset as an edge, because ovf_q resets to 0.

Configuration
REQ-029 SHALL, with macro OVF_MONITOR_PEAK_HOLD_EN defined, update peak to i_data whenever i_data > peak (unsigned) and drive o_peak from the peak register.
REQ-030 SHALL, without OVF_MONITOR_PEAK_HOLD_EN, contain no peak register and tie o_peak to 6'd0; the port list SHALL be unchanged.

Verification
REQ-031 SHALL cover: reset, then i_overflow 0->1 with i_data = 6'd5, i_evt_ready = 1 -> o_evt_valid pulses one cycle with o_evt_data = 7'h45, o_ovf_count = 1, o_alarm = 0.
REQ-032 SHALL cover: three separated overflow edges, OVF_LIMIT = 3 -> o_alarm rises on the edge where the count reaches 3; 20 further edges -> count holds at 15.
REQ-033 SHALL cover: i_evt_ready = 0, two edges -> first word retained, o_lost = 1, o_ovf_count = 2.
REQ-034 SHALL cover: i_clear coincident with an edge while in ALARM -> count 0, o_alarm 0, o_evt_valid 1.
REQ-035 SHALL cover: i_data sequence 10, 40, 20 with the macro defined -> o_peak = 40; without the macro -> o_peak = 0.
REQ-036 SHALL cover: i_rst asserted while o_evt_valid = 1 -> next cycle o_evt_valid = 0 and all outputs at reset values.
